// File: rtl/rect_filler.sv
// rect_filler: accepts one rectangle-fill command and writes it pixel by pixel, in raster order,
// into a linear framebuffer. Define RECT_CLIP_EN to clip rectangles to the visible frame.
module rect_filler #(
    parameter int unsigned H_RES  = 640,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [9:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [9:0]        cmd_h,
    input  logic [DATA_W-1:0] cmd_color,
    output logic [ADDR_W-1:0] addr_wr,
    output logic [DATA_W-1:0] data_wr,
    output logic              wr_en,
    output logic              busy,
    output logic              done
);

    if (longint'(H_RES) * longint'(V_RES) > (longint'(1) << ADDR_W)) begin : g_frame_check
        $error("rect_filler: ADDR_W too narrow for H_RES x V_RES");
    end

    typedef enum logic [1:0] {StIdle, StSetup, StFill, StDone} state_e;

    state_e state_q, state_d;

    logic [9:0]        x_q, y_q, w_q, h_q;
    logic [9:0]        col_q, row_q;
    logic [DATA_W-1:0] color_q;
    logic [ADDR_W-1:0] row_base_q, addr_q;
    logic              wr_en_q, busy_q, done_q;
    logic              wr_en_d, busy_d, done_d;

    logic [ADDR_W-1:0] x_ext, y_ext, h_res_a, row_base_setup;
    logic [9:0]        eff_w, eff_h;
    logic              accept, col_last, row_last;

    assign x_ext    = ADDR_W'(x_q);
    assign y_ext    = ADDR_W'(y_q);
    assign h_res_a  = ADDR_W'(H_RES);
    assign accept   = cmd_valid && cmd_ready;
    assign col_last = (col_q == w_q - 10'd1);
    assign row_last = (row_q == h_q - 10'd1);

    // 640 = 512 + 128, so the common case needs no multiplier.
    if (H_RES == 640) begin : g_rb_shift
        assign row_base_setup = (y_ext << 9) + (y_ext << 7);
    end else begin : g_rb_mul
        assign row_base_setup = y_ext * h_res_a;
    end

`ifdef RECT_CLIP_EN
    logic [31:0] rem_w, rem_h;
    logic        off_frame;

    always_comb begin
        off_frame = (32'(x_q) >= H_RES) || (32'(y_q) >= V_RES);
        rem_w     = H_RES - 32'(x_q);
        rem_h     = V_RES - 32'(y_q);
        eff_w     = w_q;
        eff_h     = h_q;
        if (off_frame) begin
            eff_w = '0;
            eff_h = '0;
        end else begin
            if (32'(w_q) > rem_w) eff_w = 10'(rem_w);
            if (32'(h_q) > rem_h) eff_h = 10'(rem_h);
        end
    end
`else
    assign eff_w = w_q;
    assign eff_h = h_q;
`endif

    // State register, with the registered status outputs alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StSetup;
            StSetup: state_d = (eff_w == '0 || eff_h == '0) ? StDone : StFill;
            StFill:  if (col_last && row_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the next state so they line up with it once registered.
    always_comb begin
        wr_en_d = (state_d == StFill);
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        x_q     <= cmd_x;
                        y_q     <= cmd_y;
                        w_q     <= cmd_w;
                        h_q     <= cmd_h;
                        color_q <= cmd_color;
                    end
                end
                StSetup: begin
                    w_q        <= eff_w;
                    h_q        <= eff_h;
                    row_base_q <= row_base_setup;
                    addr_q     <= row_base_setup + x_ext;
                    col_q      <= '0;
                    row_q      <= '0;
                end
                StFill: begin
                    if (col_last) begin
                        if (!row_last) begin
                            row_base_q <= row_base_q + h_res_a;
                            addr_q     <= row_base_q + h_res_a + x_ext;
                            col_q      <= '0;
                            row_q      <= row_q + 10'd1;
                        end
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                        col_q  <= col_q + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = ~busy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wr_en     = wr_en_q;
    assign addr_wr   = addr_q;
    assign data_wr   = color_q;

endmodule
